// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_tx
//  Description : Serial bit-stream transmitter for sequence-detector benches.
//                Accepts a parallel word over valid/ready and sends it on `w`
//                framed as: zero preamble, data MSB-first, zero gap.
//                Optional even-parity bit between data and gap when the macro
//                SERIAL_PATTERN_TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 2,
  parameter int GAP_LEN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              w,
  output logic              busy,
  output logic              done
);

  localparam int c_MAX_LEN = (PRE_LEN > DATA_W) ?
                             ((PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN) :
                             ((DATA_W  > GAP_LEN) ? DATA_W  : GAP_LEN);
  localparam int c_CNT_W = $clog2(c_MAX_LEN) + 1;

  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_PRE_LD  = c_CNT_W'(PRE_LEN);
  localparam logic [c_CNT_W-1:0] c_DATA_LD = c_CNT_W'(DATA_W);
  localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'(GAP_LEN);

  // One flop per state; the parity state only exists when the feature is on.
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    PRE  = 5'b00010,
    DATA = 5'b00100,
    PAR  = 5'b01000,
    GAP  = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    PRE  = 4'b0010,
    DATA = 4'b0100,
    GAP  = 4'b1000
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                w_accept;
  logic [DATA_W-1:0]   r_shift;
  logic                r_w;
  logic                r_busy;
  logic                r_done;
  logic                r_ready;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic                r_par;
`endif

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; a phase ends when its counter is at 1
  // (or 0, so a corrupted count never wraps).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (data_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PRE;
          w_cnt_nxt   = c_PRE_LD;
        end
      end
      PRE: begin
        if (r_cnt <= c_ONE) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = c_DATA_LD;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      DATA: begin
        if (r_cnt <= c_ONE) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_state_nxt = PAR;
          w_cnt_nxt   = c_ONE;
`else
          w_state_nxt = GAP;
          w_cnt_nxt   = c_GAP_LD;
`endif
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PAR: begin
        w_state_nxt = GAP;
        w_cnt_nxt   = c_GAP_LD;
      end
`endif
      GAP: begin
        if (r_cnt <= c_ONE) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath and registered outputs, all derived from the upcoming state so
  // they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_w     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_shift <= data_in;
      end else if (w_state_nxt == DATA) begin
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      if (w_accept) begin
        r_par <= ^data_in;
      end
      if (w_state_nxt == DATA) begin
        r_w <= r_shift[DATA_W-1];
      end else if (w_state_nxt == PAR) begin
        r_w <= r_par;
      end else begin
        r_w <= 1'b0;
      end
`else
      r_w     <= (w_state_nxt == DATA) ? r_shift[DATA_W-1] : 1'b0;
`endif
      r_busy  <= (w_state_nxt != IDLE);
      r_ready <= (w_state_nxt == IDLE);
      r_done  <= (w_state_nxt == GAP) && (r_state != GAP);
    end
  end

  assign w          = r_w;
  assign busy       = r_busy;
  assign done       = r_done;
  assign data_ready = r_ready;

endmodule
`default_nettype wire
